// File: rtl/nios_nios2_ocimem_pkg.sv
// Shared definitions for the OCI monitor-memory arbiter: FSM state codes and
// grant identifiers used by the round-robin between CPU and JTAG.
package nios_nios2_ocimem_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CPU_WR  = 3'd1;
   localparam state_t ST_CPU_RD  = 3'd2;
   localparam state_t ST_CPU_RDV = 3'd3;
   localparam state_t ST_JT_WR   = 3'd4;
   localparam state_t ST_JT_RD   = 3'd5;
   localparam state_t ST_JT_RDV  = 3'd6;

   localparam logic GRANT_CPU  = 1'b0;
   localparam logic GRANT_JTAG = 1'b1;

endpackage

// File: rtl/nios_nios2_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between the CPU
// Avalon-MM debug slave and the JTAG debug module's memory actions.
module nios_nios2_ocimem_arbiter
   import nios_nios2_ocimem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [ADDR_W-1:0]     avs_address,
   input  logic [DATA_W-1:0]     avs_writedata,
   input  logic [DATA_W/8-1:0]   avs_byteenable,
   output logic [DATA_W-1:0]     avs_readdata,
   output logic                  avs_waitrequest,
   input  logic                  jtag_addr_load,
   input  logic [ADDR_W-1:0]     jtag_addr_in,
   input  logic                  jtag_req,
   input  logic                  jtag_wr,
   input  logic [DATA_W-1:0]     jtag_wdata,
   input  logic                  jtag_ovf_clr,
   output logic [DATA_W-1:0]     MonDReg,
   output logic                  monitor_ready,
   output logic                  jtag_overrun,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W/8-1:0]   ram_be,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata
);

   state_t              state;
   state_t              state_nxt;
   logic                last_grant;
   logic                pending;
   logic                pend_wr;
   logic [DATA_W-1:0]   pend_wdata;
   logic [ADDR_W-1:0]   jtag_addr;

   logic                cpu_req;
   logic                jt_done;
   logic                jt_accept;
   logic                jt_want;
   logic                jt_op_wr;
   logic [DATA_W-1:0]   jt_op_wdata;
   logic                grant_cpu;
   logic                grant_jtag;

   assign cpu_req   = avs_read | avs_write;
   assign jt_done   = (state == ST_JT_WR) || (state == ST_JT_RDV);
   assign jt_accept = jtag_req && (!pending || jt_done);

   // A fresh jtag_req in IDLE competes immediately, using its own qualifiers,
   // so the op does not lose a cycle passing through the pending register.
   assign jt_want     = pending | jtag_req;
   assign jt_op_wr    = pending ? pend_wr    : jtag_wr;
   assign jt_op_wdata = pending ? pend_wdata : jtag_wdata;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      grant_cpu  = 1'b0;
      grant_jtag = 1'b0;
      if (state == ST_IDLE) begin
         if (cpu_req && jt_want) begin
            if (last_grant == GRANT_CPU) grant_jtag = 1'b1;
            else                         grant_cpu  = 1'b1;
         end else if (jt_want) begin
            grant_jtag = 1'b1;
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (grant_jtag)     state_nxt = jt_op_wr  ? ST_JT_WR  : ST_JT_RD;
            else if (grant_cpu) state_nxt = avs_write ? ST_CPU_WR : ST_CPU_RD;
         end
         ST_CPU_RD: state_nxt = ST_CPU_RDV;
         ST_JT_RD:  state_nxt = ST_JT_RDV;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign avs_waitrequest = cpu_req && !((state == ST_CPU_WR) || (state == ST_CPU_RDV));
   assign avs_readdata    = (state == ST_CPU_RDV) ? ram_rdata : '0;
   assign monitor_ready   = !pending;

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         last_grant <= GRANT_CPU;
      end else begin
         state <= state_nxt;
         if (grant_jtag)     last_grant <= GRANT_JTAG;
         else if (grant_cpu) last_grant <= GRANT_CPU;
      end
   end

   // RAM strobes are one-cycle pulses launched from the granting IDLE cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_be    <= '0;
         ram_wdata <= '0;
      end else begin
         ram_en <= 1'b0;
         ram_we <= 1'b0;
         if (grant_jtag) begin
            ram_en    <= 1'b1;
            ram_we    <= jt_op_wr;
            ram_addr  <= jtag_addr;
            ram_be    <= '1;
            ram_wdata <= jt_op_wdata;
         end else if (grant_cpu) begin
            ram_en    <= 1'b1;
            ram_we    <= avs_write;
            ram_addr  <= avs_address;
            ram_be    <= avs_byteenable;
            ram_wdata <= avs_writedata;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending      <= 1'b0;
         pend_wr      <= 1'b0;
         pend_wdata   <= '0;
         jtag_addr    <= '0;
         MonDReg      <= '0;
         jtag_overrun <= 1'b0;
      end else begin
         // The address only moves when no op is outstanding; completion wins.
         if (jt_done) begin
            pending   <= 1'b0;
            jtag_addr <= jtag_addr + 1'b1;
         end else if (jtag_addr_load && !pending) begin
            jtag_addr <= jtag_addr_in;
         end
         if (jt_accept) begin
            pending    <= 1'b1;
            pend_wr    <= jtag_wr;
            pend_wdata <= jtag_wdata;
         end
         if (state == ST_JT_RDV) MonDReg <= ram_rdata;
         if (jtag_req && pending && !jt_done) jtag_overrun <= 1'b1;
         else if (jtag_ovf_clr)               jtag_overrun <= 1'b0;
      end
   end

endmodule
